bnn_argmax_out: RTL and testbench

//  Output stage directly downstream of the BNN top: consumes the 10 per-class popcount scores
//  (10 x 7 bit) and reduces them to a single predicted class index plus its score.

---
 rtl/bnn_out_pkg.sv | 17 +
 rtl/bnn_argmax_cmp.sv | 53 +++++
 rtl/bnn_argmax_out.sv | 171 +++++++++++++++++
 tb/tb_bnn_argmax_out.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bnn_out_pkg.sv
// Shared constants and types for the BNN argmax output stage.
package bnn_out_pkg;

    localparam int NUM_CLASSES_DEF = 10;
    localparam int SCORE_W_DEF     = 7;
    localparam int CLASS_W_DEF     = $clog2(NUM_CLASSES_DEF);

    typedef logic [SCORE_W_DEF-1:0] score_t;
    typedef logic [CLASS_W_DEF-1:0] class_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/bnn_argmax_cmp.sv
// Combinational compare/update cell for the sequential argmax scan.
// Optional: BNN_ARGMAX_TOP2_EN also tracks the runner-up score and index.
// Strict ">" everywhere, so the lowest index holding a given value wins.
module bnn_argmax_cmp #(
    parameter int SCORE_W = 7,
    parameter int CLASS_W = 4
) (
    input  logic [SCORE_W-1:0] cand_i,
    input  logic [CLASS_W-1:0] cand_idx_i,
    input  logic [SCORE_W-1:0] best_i,
    input  logic [CLASS_W-1:0] best_idx_i,
`ifdef BNN_ARGMAX_TOP2_EN
    input  logic [SCORE_W-1:0] second_i,
    input  logic [CLASS_W-1:0] second_idx_i,
    input  logic               has_second_i,
    output logic [SCORE_W-1:0] second_o,
    output logic [CLASS_W-1:0] second_idx_o,
    output logic               has_second_o,
`endif
    output logic [SCORE_W-1:0] best_o,
    output logic [CLASS_W-1:0] best_idx_o
);

    // Update the running best (and runner-up) with one candidate score.
    always_comb begin
        best_o     = best_i;
        best_idx_o = best_idx_i;
`ifdef BNN_ARGMAX_TOP2_EN
        second_o     = second_i;
        second_idx_o = second_idx_i;
        has_second_o = has_second_i;
        if (cand_i > best_i) begin
            // The old best is demoted to runner-up.
            best_o       = cand_i;
            best_idx_o   = cand_idx_i;
            second_o     = best_i;
            second_idx_o = best_idx_i;
            has_second_o = 1'b1;
        end else if (!has_second_i || (cand_i > second_i)) begin
            // First non-best candidate always seeds the runner-up slot.
            second_o     = cand_i;
            second_idx_o = cand_idx_i;
            has_second_o = 1'b1;
        end
`else
        if (cand_i > best_i) begin
            best_o     = cand_i;
            best_idx_o = cand_idx_i;
        end
`endif
    end

endmodule

// File: rtl/bnn_argmax_out.sv
// BNN output stage: captures 10 class scores, scans them one per cycle and
// presents the winning class index and its score on a valid/ready port.
// Optional: BNN_ARGMAX_TOP2_EN adds second_class_o and margin_o.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. scores_valid_i must be held until scores_ready_o (IDLE only);
// valid_o is held with stable class_o/score_o until ready_i is seen.
module bnn_argmax_out
    import bnn_out_pkg::*;
#(
    parameter int NUM_CLASSES = NUM_CLASSES_DEF,
    parameter int SCORE_W     = SCORE_W_DEF,
    parameter int CLASS_W     = $clog2(NUM_CLASSES)
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic [NUM_CLASSES-1:0][SCORE_W-1:0] scores_i,
    input  logic                                scores_valid_i,
    output logic                                scores_ready_o,
    output logic [CLASS_W-1:0]                  class_o,
    output logic [SCORE_W-1:0]                  score_o,
`ifdef BNN_ARGMAX_TOP2_EN
    output logic [CLASS_W-1:0]                  second_class_o,
    output logic [SCORE_W-1:0]                  margin_o,
`endif
    output logic                                valid_o,
    input  logic                                ready_i
);

    localparam logic [CLASS_W-1:0] LAST_IDX = CLASS_W'(NUM_CLASSES - 1);

    state_e                                state_q, state_d;
    logic [NUM_CLASSES-1:0][SCORE_W-1:0]   cap_q, cap_d;
    logic [CLASS_W-1:0]                    idx_q, idx_d;
    logic [SCORE_W-1:0]                    best_q, best_d, upd_best;
    logic [CLASS_W-1:0]                    best_idx_q, best_idx_d, upd_best_idx;
    logic [CLASS_W-1:0]                    class_q, class_d;
    logic [SCORE_W-1:0]                    score_q, score_d;
`ifdef BNN_ARGMAX_TOP2_EN
    logic [SCORE_W-1:0]                    second_q, second_d, upd_second;
    logic [CLASS_W-1:0]                    second_idx_q, second_idx_d, upd_second_idx;
    logic                                  has_second_q, has_second_d, upd_has_second;
    logic [CLASS_W-1:0]                    second_class_q, second_class_d;
    logic [SCORE_W-1:0]                    margin_q, margin_d;
`endif

    assign scores_ready_o = (state_q == IDLE);
    assign valid_o        = (state_q == DONE);
    assign class_o        = class_q;
    assign score_o        = score_q;
`ifdef BNN_ARGMAX_TOP2_EN
    assign second_class_o = second_class_q;
    assign margin_o       = margin_q;
`endif

    bnn_argmax_cmp #(
        .SCORE_W (SCORE_W),
        .CLASS_W (CLASS_W)
    ) u_cmp (
        .cand_i       (cap_q[idx_q]),
        .cand_idx_i   (idx_q),
        .best_i       (best_q),
        .best_idx_i   (best_idx_q),
`ifdef BNN_ARGMAX_TOP2_EN
        .second_i     (second_q),
        .second_idx_i (second_idx_q),
        .has_second_i (has_second_q),
        .second_o     (upd_second),
        .second_idx_o (upd_second_idx),
        .has_second_o (upd_has_second),
`endif
        .best_o       (upd_best),
        .best_idx_o   (upd_best_idx)
    );

    // Next-state logic: capture in IDLE, one class per cycle in SCAN, hold in DONE.
    always_comb begin
        state_d    = state_q;
        cap_d      = cap_q;
        idx_d      = idx_q;
        best_d     = best_q;
        best_idx_d = best_idx_q;
        class_d    = class_q;
        score_d    = score_q;
`ifdef BNN_ARGMAX_TOP2_EN
        second_d       = second_q;
        second_idx_d   = second_idx_q;
        has_second_d   = has_second_q;
        second_class_d = second_class_q;
        margin_d       = margin_q;
`endif
        case (state_q)
            IDLE: begin
                if (scores_valid_i) begin
                    cap_d      = scores_i;
                    best_d     = scores_i[0];
                    best_idx_d = '0;
                    idx_d      = CLASS_W'(1);
`ifdef BNN_ARGMAX_TOP2_EN
                    second_d     = '0;
                    second_idx_d = '0;
                    has_second_d = 1'b0;
`endif
                    state_d    = SCAN;
                end
            end
            SCAN: begin
                best_d     = upd_best;
                best_idx_d = upd_best_idx;
                idx_d      = idx_q + CLASS_W'(1);
`ifdef BNN_ARGMAX_TOP2_EN
                second_d     = upd_second;
                second_idx_d = upd_second_idx;
                has_second_d = upd_has_second;
`endif
                if (idx_q == LAST_IDX) begin
                    class_d = upd_best_idx;
                    score_d = upd_best;
`ifdef BNN_ARGMAX_TOP2_EN
                    second_class_d = upd_second_idx;
                    margin_d       = upd_best - upd_second;
`endif
                    idx_d   = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset discards any operation in flight.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            cap_q      <= '0;
            idx_q      <= '0;
            best_q     <= '0;
            best_idx_q <= '0;
            class_q    <= '0;
            score_q    <= '0;
`ifdef BNN_ARGMAX_TOP2_EN
            second_q       <= '0;
            second_idx_q   <= '0;
            has_second_q   <= 1'b0;
            second_class_q <= '0;
            margin_q       <= '0;
`endif
        end else begin
            state_q    <= state_d;
            cap_q      <= cap_d;
            idx_q      <= idx_d;
            best_q     <= best_d;
            best_idx_q <= best_idx_d;
            class_q    <= class_d;
            score_q    <= score_d;
`ifdef BNN_ARGMAX_TOP2_EN
            second_q       <= second_d;
            second_idx_q   <= second_idx_d;
            has_second_q   <= has_second_d;
            second_class_q <= second_class_d;
            margin_q       <= margin_d;
`endif
        end
    end

endmodule

// File: tb/tb_bnn_argmax_out.sv
// Bench for bnn_argmax_out: directed score vectors, expected results queued
// at accept time and checked by an independent output monitor.
// Optional: BNN_ARGMAX_TOP2_EN also checks second_class_o and margin_o.
module tb_bnn_argmax_out;
  import bnn_out_pkg::*;

  localparam int NC  = NUM_CLASSES_DEF;
  localparam int SW  = SCORE_W_DEF;
  localparam int CW  = CLASS_W_DEF;
  localparam int LAT = NC - 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_i = 1'b1;
  always #5 clk = ~clk;

  logic [NC-1:0][SW-1:0] scores_i = '0;
  logic                  scores_valid_i = 1'b0;
  logic                  scores_ready_o;
  class_t                class_o;
  score_t                score_o;
  logic                  valid_o;
  logic                  ready_i = 1'b1;
`ifdef BNN_ARGMAX_TOP2_EN
  class_t                second_class_o;
  score_t                margin_o;
`endif

  bnn_argmax_out dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .scores_i       (scores_i),
    .scores_valid_i (scores_valid_i),
    .scores_ready_o (scores_ready_o),
    .class_o        (class_o),
    .score_o        (score_o),
`ifdef BNN_ARGMAX_TOP2_EN
    .second_class_o (second_class_o),
    .margin_o       (margin_o),
`endif
    .valid_o        (valid_o),
    .ready_i        (ready_i)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  // {class, score, second_class, margin}
  logic [2*CW+2*SW-1:0] exp_q[$];
  int                   lat_q[$];
  int total = 0;
  int bad = 0;
  int pop_cyc = 0;

  task automatic chk(input string nm, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // ---------------- driver ----------------
  task automatic send(input logic [NC*SW-1:0] v, input int ec, input int es,
                      input int e2, input int em, output int acc);
    int waited;
    waited = 0;
    acc = -1;
    @(negedge clk);
    scores_i = v;
    scores_valid_i = 1'b1;
    while (!scores_ready_o && waited < 60) begin
      @(negedge clk);
      waited++;
    end
    if (!scores_ready_o) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: scores_ready_o stayed 0 for %0d cycles", waited);
      scores_valid_i = 1'b0;
    end else begin
      acc = cyc + 1;
      exp_q.push_back({CW'(ec), SW'(es), CW'(e2), SW'(em)});
      lat_q.push_back(cyc + 1);
      @(posedge clk);
      #1;
      scores_valid_i = 1'b0;
      scores_i = '1;  // junk after capture; must be ignored
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: %0d results outstanding", exp_q.size());
      exp_q.delete();
      lat_q.delete();
    end
  endtask

  // ---------------- monitor ----------------
  logic   prev_valid = 1'b0;
  class_t held_cls;
  score_t held_score;

  always begin
    logic [2*CW+2*SW-1:0] e;
    int a;
    @(negedge clk);
    #2;
    if (rst_i) begin
      prev_valid = 1'b0;
    end else begin
      if (valid_o && !prev_valid) begin
        if (lat_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_valid: valid_o=1 with nothing outstanding");
        end else begin
          a = lat_q.pop_front();
          chk("latency", cyc - a, LAT);
        end
        held_cls   = class_o;
        held_score = score_o;
      end else if (valid_o && prev_valid) begin
        chk("hold_class", int'(class_o), int'(held_cls));
        chk("hold_score", int'(score_o), int'(held_score));
      end
      if (valid_o && ready_i) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_result: class=%0d score=%0d", class_o, score_o);
        end else begin
          e = exp_q.pop_front();
          chk("class", int'(class_o), int'(e[2*CW+2*SW-1 -: CW]));
          chk("score", int'(score_o), int'(e[CW+2*SW-1 -: SW]));
`ifdef BNN_ARGMAX_TOP2_EN
          chk("second_class", int'(second_class_o), int'(e[CW+SW-1 -: CW]));
          chk("margin", int'(margin_o), int'(e[SW-1:0]));
`endif
        end
        pop_cyc = cyc + 1;
      end
      prev_valid = valid_o;
    end
  end

  // ---------------- stimulus ----------------
  // Vectors written c9 first, c0 last.
  localparam logic [NC*SW-1:0] V_UNIQ = {7'd7, 7'd63, 7'd2, 7'd1, 7'd0, 7'd0, 7'd5, 7'd64, 7'd10, 7'd3};
  localparam logic [NC*SW-1:0] V_TIE  = {7'd20, 7'd20, 7'd50, 7'd20, 7'd20, 7'd50, 7'd20, 7'd20, 7'd20, 7'd20};
  localparam logic [NC*SW-1:0] V_ZERO = '0;
  localparam logic [NC*SW-1:0] V_MAX9 = {7'd127, 7'd126, 7'd126, 7'd126, 7'd126, 7'd126, 7'd126, 7'd126, 7'd126, 7'd126};
  localparam logic [NC*SW-1:0] V_MAX0 = {7'd126, 7'd126, 7'd126, 7'd126, 7'd126, 7'd126, 7'd126, 7'd126, 7'd126, 7'd127};
  localparam logic [NC*SW-1:0] V_RAMP = {7'd10, 7'd9, 7'd8, 7'd7, 7'd6, 7'd5, 7'd4, 7'd3, 7'd2, 7'd1};
  localparam logic [NC*SW-1:0] V_MID5 = {7'd99, 7'd99, 7'd99, 7'd99, 7'd100, 7'd99, 7'd99, 7'd99, 7'd99, 7'd99};

  initial begin
    int acc_a, acc_b, n;

    // power-on reset, checked before any clock edge
    #3;
    chk("por_ready", int'(scores_ready_o), 1);
    chk("por_valid", int'(valid_o), 0);
    chk("por_class", int'(class_o), 0);
    chk("por_score", int'(score_o), 0);
    repeat (2) @(negedge clk);
    rst_i = 1'b0;

    // unique maximum
    ready_i = 1'b1;
    send(V_UNIQ, 2, 64, 8, 1, acc_a);
    wait_drain();

    // asynchronous reset mid-cycle clears the held result immediately
    @(posedge clk);
    #1 rst_i = 1'b1;
    #1;
    chk("arst_class", int'(class_o), 0);
    chk("arst_score", int'(score_o), 0);
    chk("arst_valid", int'(valid_o), 0);
    chk("arst_ready", int'(scores_ready_o), 1);
    #1 rst_i = 1'b0;

    // ties and all-zero
    send(V_TIE, 4, 50, 7, 0, acc_a);
    send(V_ZERO, 0, 0, 1, 0, acc_a);
    // boundaries at both ends
    send(V_MAX9, 9, 127, 0, 1, acc_a);
    send(V_MAX0, 0, 127, 1, 1, acc_a);
    wait_drain();

    // backpressure: result held, next vector waits until ready_i
    ready_i = 1'b0;
    send(V_TIE, 4, 50, 7, 0, acc_a);
    fork
      send(V_RAMP, 9, 10, 8, 1, acc_b);
      begin
        n = 0;
        while (!valid_o && n < 40) begin
          @(negedge clk);
          n++;
        end
        chk("bp_valid_seen", int'(valid_o), 1);
        repeat (5) begin
          @(negedge clk);
          #1;
          chk("bp_ready_low", int'(scores_ready_o), 0);
          chk("bp_valid_held", int'(valid_o), 1);
        end
        @(negedge clk);
        ready_i = 1'b1;
      end
    join
    chk("bp_accept_next_cycle", acc_b, pop_cyc + 1);
    wait_drain();

    // reset during SCAN drops the vector
    send(V_UNIQ, 2, 64, 8, 1, acc_a);
    repeat (4) @(posedge clk);
    #1 rst_i = 1'b1;
    #2 rst_i = 1'b0;
    exp_q.delete();
    lat_q.delete();
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      #1;
      chk("no_valid_after_rst", int'(valid_o), 0);
    end
    send(V_MID5, 5, 100, 0, 1, acc_a);
    wait_drain();

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
